// File: rtl/decode_pkg.sv
// Shared definitions for the RV32IMF decode stage: opcodes, op-code enums,
// control-word bit positions and the micro-op record stored in the queue.
package decode_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_MADD     = 7'b1000011;
  localparam logic [6:0] OPC_MSUB     = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
  localparam logic [6:0] OPC_NMADD    = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Integer ALU / multiply / divide operations. The first eight follow
  // funct3 of OP/OP-IMM, and the M extension follows funct3 from 10 upward.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SLL    = 5'd1,
    ALU_SLT    = 5'd2,
    ALU_SLTU   = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SRL    = 5'd5,
    ALU_OR     = 5'd6,
    ALU_AND    = 5'd7,
    ALU_SUB    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  // Single-precision FPU operations; 0 means the micro-op uses no FPU.
  typedef enum logic [4:0] {
    FPU_NONE    = 5'd0,
    FPU_FADD    = 5'd1,
    FPU_FSUB    = 5'd2,
    FPU_FMUL    = 5'd3,
    FPU_FDIV    = 5'd4,
    FPU_FSQRT   = 5'd5,
    FPU_FMADD   = 5'd6,
    FPU_FMSUB   = 5'd7,
    FPU_FNMADD  = 5'd8,
    FPU_FNMSUB  = 5'd9,
    FPU_FSGNJ   = 5'd11,
    FPU_FSGNJN  = 5'd12,
    FPU_FSGNJX  = 5'd13,
    FPU_FEQ     = 5'd14,
    FPU_FLT     = 5'd15,
    FPU_FLE     = 5'd16,
    FPU_FCVT_SW  = 5'd19,
    FPU_FCVT_SWU = 5'd20,
    FPU_FCVT_WS  = 5'd21,
    FPU_FCVT_WUS = 5'd22,
    FPU_FMV     = 5'd23,
    FPU_FMIN    = 5'd24,
    FPU_FMAX    = 5'd25,
    FPU_FCLASS  = 5'd26
  } fpu_op_e;

  // Immediate format selected for the execute stage.
  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_SHAMT = 3'd2,
    IMM_S     = 3'd3,
    IMM_B     = 3'd4,
    IMM_U     = 3'd5,
    IMM_J     = 3'd6
  } imm_sel_e;

  // Operand-source code packed into ctrl[1:0]. FSTORE is an address of
  // rs1+imm whose store data comes from the FP register file.
  typedef enum logic [1:0] {
    SRC_RS1_RS2 = 2'd0,
    SRC_RS1_IMM = 2'd1,
    SRC_PC_IMM  = 2'd2,
    SRC_FSTORE  = 2'd3
  } src_sel_e;

  // Control-word bit positions
  localparam int CTRL_W       = 12;
  localparam int CTRL_MEM_RD  = 11;
  localparam int CTRL_MEM_WR  = 10;
  localparam int CTRL_JUMP    = 9;
  localparam int CTRL_BRANCH  = 8;
  localparam int CTRL_JALR    = 7;
  localparam int CTRL_REG_WR  = 6;
  localparam int CTRL_FREG_WR = 5;
  localparam int CTRL_WB_MEM  = 4;
  localparam int CTRL_ITOF    = 3;
  localparam int CTRL_FTOI    = 2;
  localparam int CTRL_SRC_LSB = 0;

  // Decoded micro-op (PC is carried alongside it in the queue)
  typedef struct packed {
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rs3;
    alu_op_e           alu_op;
    fpu_op_e           fpu_op;
    imm_sel_e          imm_sel;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
  } uop_t;

  localparam int UOP_W = $bits(uop_t);

endpackage

// File: rtl/uop_decoder.sv
// Purely combinational RV32IMF decoder: raw instruction -> micro-op.
// Register index fields are extracted verbatim (rs3 only for R4 formats);
// the write/memory enables say which of them are meaningful.
module uop_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output uop_t        uop_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] f5;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;
  logic [1:0] fmt;
  logic       rm_ok;

  assign opcode = instr_i[6:0];
  assign rd_f   = instr_i[11:7];
  assign f3     = instr_i[14:12];
  assign rs2_f  = instr_i[24:20];
  assign f7     = instr_i[31:25];
  assign f5     = instr_i[31:27];
  assign fmt    = instr_i[26:25];
  // Rounding modes 101 and 110 are reserved.
  assign rm_ok  = (f3 != 3'b101) && (f3 != 3'b110);

  logic     mem_rd, mem_wr, jump, branch, jalr, reg_wr, freg_wr, wb_mem, itof, ftoi;
  logic     illegal;
  logic [4:0] rs3;
  src_sel_e src;
  alu_op_e  alu;
  fpu_op_e  fpu;
  imm_sel_e imm;

  // Decode opcode/funct fields into op codes, flags and the illegal marker.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    jump    = 1'b0;
    branch  = 1'b0;
    jalr    = 1'b0;
    reg_wr  = 1'b0;
    freg_wr = 1'b0;
    wb_mem  = 1'b0;
    itof    = 1'b0;
    ftoi    = 1'b0;
    illegal = 1'b0;
    rs3     = 5'd0;
    src     = SRC_RS1_RS2;
    alu     = ALU_ADD;
    fpu     = FPU_NONE;
    imm     = IMM_I;

    case (opcode)
      OPC_LUI: begin
        reg_wr = 1'b1;
        src    = SRC_RS1_IMM;
        imm    = IMM_U;
      end
      OPC_AUIPC: begin
        reg_wr = 1'b1;
        src    = SRC_PC_IMM;
        imm    = IMM_U;
      end
      OPC_JAL: begin
        jump   = 1'b1;
        reg_wr = 1'b1;
        src    = SRC_PC_IMM;
        imm    = IMM_J;
      end
      OPC_JALR: begin
        jump   = 1'b1;
        jalr   = 1'b1;
        reg_wr = 1'b1;
        src    = SRC_RS1_IMM;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        imm    = IMM_B;
        case (f3[2:1])
          2'b00:   alu = ALU_SUB;
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        mem_rd = 1'b1;
        reg_wr = 1'b1;
        wb_mem = 1'b1;
        src    = SRC_RS1_IMM;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
      end
      OPC_STORE: begin
        mem_wr = 1'b1;
        src    = SRC_RS1_IMM;
        imm    = IMM_S;
        if (f3[2] || f3 == 3'b011) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        reg_wr = 1'b1;
        src    = SRC_RS1_IMM;
        alu    = alu_op_e'({2'b00, f3});
        if (f3 == 3'b001) begin
          imm = IMM_SHAMT;
          if (f7 != 7'b0000000) illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          imm = IMM_SHAMT;
          if (f7 == 7'b0100000) alu = ALU_SRA;
          else if (f7 != 7'b0000000) illegal = 1'b1;
        end
      end
      OPC_OP: begin
        reg_wr = 1'b1;
        case (f7)
          7'b0000000: alu = alu_op_e'({2'b00, f3});
          7'b0100000: begin
            if (f3 == 3'b000)      alu = ALU_SUB;
            else if (f3 == 3'b101) alu = ALU_SRA;
            else                   illegal = 1'b1;
          end
          7'b0000001: alu = alu_op_e'(5'd10 + {2'b00, f3});
          default:    illegal = 1'b1;
        endcase
      end
      OPC_MISC_MEM: begin
        // fence / fence.i: ordering hints only, no register or memory write
        if (f3[2:1] != 2'b00) illegal = 1'b1;
      end
      OPC_LOAD_FP: begin
        mem_rd  = 1'b1;
        freg_wr = 1'b1;
        wb_mem  = 1'b1;
        src     = SRC_RS1_IMM;
        if (f3 != 3'b010) illegal = 1'b1;
      end
      OPC_STORE_FP: begin
        mem_wr = 1'b1;
        src    = SRC_FSTORE;
        imm    = IMM_S;
        if (f3 != 3'b010) illegal = 1'b1;
      end
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
        freg_wr = 1'b1;
        rs3     = instr_i[31:27];
        case (opcode)
          OPC_MADD:  fpu = FPU_FMADD;
          OPC_MSUB:  fpu = FPU_FMSUB;
          OPC_NMSUB: fpu = FPU_FNMSUB;
          default:   fpu = FPU_FNMADD;
        endcase
        if (fmt != 2'b00 || !rm_ok) illegal = 1'b1;
      end
      OPC_OP_FP: begin
        freg_wr = 1'b1;
        case (f5)
          5'b00000: fpu = FPU_FADD;
          5'b00001: fpu = FPU_FSUB;
          5'b00010: fpu = FPU_FMUL;
          5'b00011: fpu = FPU_FDIV;
          5'b01011: begin
            fpu = FPU_FSQRT;
            if (rs2_f != 5'd0) illegal = 1'b1;
          end
          5'b00100: begin
            case (f3)
              3'b000:  fpu = FPU_FSGNJ;
              3'b001:  fpu = FPU_FSGNJN;
              3'b010:  fpu = FPU_FSGNJX;
              default: illegal = 1'b1;
            endcase
          end
          5'b00101: begin
            case (f3)
              3'b000:  fpu = FPU_FMIN;
              3'b001:  fpu = FPU_FMAX;
              default: illegal = 1'b1;
            endcase
          end
          5'b10100: begin
            freg_wr = 1'b0;
            reg_wr  = 1'b1;
            case (f3)
              3'b010:  fpu = FPU_FEQ;
              3'b001:  fpu = FPU_FLT;
              3'b000:  fpu = FPU_FLE;
              default: illegal = 1'b1;
            endcase
          end
          5'b11000: begin
            freg_wr = 1'b0;
            reg_wr  = 1'b1;
            ftoi    = 1'b1;
            if (rs2_f == 5'd0)      fpu = FPU_FCVT_WS;
            else if (rs2_f == 5'd1) fpu = FPU_FCVT_WUS;
            else                    illegal = 1'b1;
          end
          5'b11010: begin
            itof = 1'b1;
            if (rs2_f == 5'd0)      fpu = FPU_FCVT_SW;
            else if (rs2_f == 5'd1) fpu = FPU_FCVT_SWU;
            else                    illegal = 1'b1;
          end
          5'b11100: begin
            freg_wr = 1'b0;
            reg_wr  = 1'b1;
            ftoi    = 1'b1;
            if (rs2_f != 5'd0)      illegal = 1'b1;
            else if (f3 == 3'b000)  fpu = FPU_FMV;
            else if (f3 == 3'b001)  fpu = FPU_FCLASS;
            else                    illegal = 1'b1;
          end
          5'b11110: begin
            itof = 1'b1;
            fpu  = FPU_FMV;
            if (rs2_f != 5'd0 || f3 != 3'b000) illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
        // Arithmetic and conversions take a rounding mode in funct3.
        if ((f5[4:2] == 3'b000 || f5 == 5'b01011 || f5 == 5'b11000 || f5 == 5'b11010)
            && !rm_ok) illegal = 1'b1;
        if (fmt != 2'b00) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // An illegal micro-op carries no side effects, only the exception marker.
    if (illegal) begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      jump    = 1'b0;
      branch  = 1'b0;
      jalr    = 1'b0;
      reg_wr  = 1'b0;
      freg_wr = 1'b0;
      wb_mem  = 1'b0;
      itof    = 1'b0;
      ftoi    = 1'b0;
      src     = SRC_RS1_RS2;
      alu     = ALU_ADD;
      fpu     = FPU_NONE;
      imm     = IMM_I;
    end else if (rd_f == 5'd0) begin
      reg_wr = 1'b0;
    end
  end

  // Assemble the micro-op record.
  always_comb begin
    uop_o         = '0;
    uop_o.rd      = rd_f;
    uop_o.rs1     = instr_i[19:15];
    uop_o.rs2     = rs2_f;
    uop_o.rs3     = rs3;
    uop_o.alu_op  = alu;
    uop_o.fpu_op  = fpu;
    uop_o.imm_sel = imm;
    uop_o.ctrl    = {mem_rd, mem_wr, jump, branch, jalr, reg_wr, freg_wr,
                     wb_mem, itof, ftoi, src};
    uop_o.illegal = illegal;
  end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes the offered instruction and buffers the
// micro-op with its PC in a DEPTH-entry FIFO in program order.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready, and ready here depends only on
// registered occupancy (no pass-through). flush wins over both transfers.
module decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rs3,
  output logic [4:0]       out_alu_op,
  output logic [4:0]       out_fpu_op,
  output logic [2:0]       out_imm_sel,
  output logic [11:0]      out_ctrl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    uop_t            uop;
  } entry_t;

  uop_t       dec_uop;
  entry_t     mem_q [DEPTH];
  entry_t     head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push, pop;

  uop_decoder u_dec (
    .instr_i (in_instr[31:0]),
    .uop_o   (dec_uop)
  );

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Next pointers and occupancy; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, uop: dec_uop};
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_pc      = head.pc;
  assign out_rd      = head.uop.rd;
  assign out_rs1     = head.uop.rs1;
  assign out_rs2     = head.uop.rs2;
  assign out_rs3     = head.uop.rs3;
  assign out_alu_op  = head.uop.alu_op;
  assign out_fpu_op  = head.uop.fpu_op;
  assign out_imm_sel = head.uop.imm_sel;
  assign out_ctrl    = head.uop.ctrl;
  assign out_illegal = head.uop.illegal;
  assign count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: per-instruction decode vectors, ordering,
// back-pressure, flush and asynchronous reset.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [4:0]       out_rd, out_rs1, out_rs2, out_rs3;
  logic [4:0]       out_alu_op, out_fpu_op;
  logic [2:0]       out_imm_sel;
  logic [11:0]      out_ctrl;
  logic             out_illegal;
  logic [CNT_W-1:0] count;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [31:0] exp_q[$];

  decode_queue #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rs3     (out_rs3),
    .out_alu_op  (out_alu_op),
    .out_fpu_op  (out_fpu_op),
    .out_imm_sel (out_imm_sel),
    .out_ctrl    (out_ctrl),
    .out_illegal (out_illegal),
    .count       (count)
  );

  // Clock
  always #5 clk = ~clk;

  // Hand-decoded vectors; ctrl = {mem_rd,mem_wr,jump,branch,jalr,reg_wr,
  // freg_wr,wb_mem,itof,ftoi,src[1:0]}
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2, rs3, alu, fpu;
    logic [2:0]  imm;
    logic [11:0] ctrl;
    logic        ill;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    vecs[0]  = '{32'h002081B3, 5'd3,  5'd1,  5'd2,  5'd0, 5'd0,  5'd0, 3'd0, 12'h040, 1'b0}; // add x3,x1,x2
    vecs[1]  = '{32'h027302B3, 5'd5,  5'd6,  5'd7,  5'd0, 5'd10, 5'd0, 3'd0, 12'h040, 1'b0}; // mul x5,x6,x7
    vecs[2]  = '{32'h403150B3, 5'd1,  5'd2,  5'd3,  5'd0, 5'd9,  5'd0, 3'd0, 12'h040, 1'b0}; // sra x1,x2,x3
    vecs[3]  = '{32'h003100D3, 5'd1,  5'd2,  5'd3,  5'd0, 5'd0,  5'd1, 3'd0, 12'h020, 1'b0}; // fadd.s
    vecs[4]  = '{32'h203100C3, 5'd1,  5'd2,  5'd3,  5'd4, 5'd0,  5'd6, 3'd0, 12'h020, 1'b0}; // fmadd.s rs3=f4
    vecs[5]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0,  5'd0, 3'd0, 12'h000, 1'b1}; // unknown opcode
    vecs[6]  = '{32'h00000013, 5'd0,  5'd0,  5'd0,  5'd0, 5'd0,  5'd0, 3'd0, 12'h001, 1'b0}; // addi x0 -> no reg_wr
    vecs[7]  = '{32'h0080A283, 5'd5,  5'd1,  5'd8,  5'd0, 5'd0,  5'd0, 3'd0, 12'h851, 1'b0}; // lw x5,8(x1)
    vecs[8]  = '{32'h0020A223, 5'd4,  5'd1,  5'd2,  5'd0, 5'd0,  5'd0, 3'd3, 12'h401, 1'b0}; // sw x2,4(x1)
    vecs[9]  = '{32'h00208463, 5'd8,  5'd1,  5'd2,  5'd0, 5'd8,  5'd0, 3'd4, 12'h100, 1'b0}; // beq x1,x2,8
    vecs[10] = '{32'h010000EF, 5'd1,  5'd0,  5'd16, 5'd0, 5'd0,  5'd0, 3'd6, 12'h242, 1'b0}; // jal x1,16
    vecs[11] = '{32'h00311093, 5'd1,  5'd2,  5'd3,  5'd0, 5'd1,  5'd0, 3'd2, 12'h041, 1'b0}; // slli x1,x2,3
    vecs[12] = '{32'h403110B3, 5'd1,  5'd2,  5'd3,  5'd0, 5'd0,  5'd0, 3'd0, 12'h000, 1'b1}; // funct7 0100000 f3 001
    vecs[13] = '{32'h023100D3, 5'd1,  5'd2,  5'd3,  5'd0, 5'd0,  5'd0, 3'd0, 12'h000, 1'b1}; // fadd.d, fmt=01
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic check_head(input int idx, input logic [31:0] pc);
    check_eq($sformatf("v%0d.valid", idx),   {31'd0, out_valid},   32'd1);
    check_eq($sformatf("v%0d.pc", idx),      out_pc,               pc);
    check_eq($sformatf("v%0d.rd", idx),      {27'd0, out_rd},      {27'd0, vecs[idx].rd});
    check_eq($sformatf("v%0d.rs1", idx),     {27'd0, out_rs1},     {27'd0, vecs[idx].rs1});
    check_eq($sformatf("v%0d.rs2", idx),     {27'd0, out_rs2},     {27'd0, vecs[idx].rs2});
    check_eq($sformatf("v%0d.rs3", idx),     {27'd0, out_rs3},     {27'd0, vecs[idx].rs3});
    check_eq($sformatf("v%0d.alu", idx),     {27'd0, out_alu_op},  {27'd0, vecs[idx].alu});
    check_eq($sformatf("v%0d.fpu", idx),     {27'd0, out_fpu_op},  {27'd0, vecs[idx].fpu});
    check_eq($sformatf("v%0d.imm", idx),     {29'd0, out_imm_sel}, {29'd0, vecs[idx].imm});
    check_eq($sformatf("v%0d.ctrl", idx),    {20'd0, out_ctrl},    {20'd0, vecs[idx].ctrl});
    check_eq($sformatf("v%0d.illegal", idx), {31'd0, out_illegal}, {31'd0, vecs[idx].ill});
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops;
    int cyc;
    logic accepted;
    logic [31:0] exp_pc;

    // Reset
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0);
    #12;
    rst = 1'b0;
    #1;
    check_eq("rst.count",     {29'd0, count},      32'd0);
    check_eq("rst.out_valid", {31'd0, out_valid},  32'd0);
    check_eq("rst.in_ready",  {31'd0, in_ready},   32'd1);
    tick();

    // Single-instruction decode vectors: push, inspect head, pop
    for (int i = 0; i < NVEC; i++) begin
      drive_in(1'b1, vecs[i].instr, 32'h100 + 32'(4 * i));
      tick();
      drive_in(1'b0, 32'h0, 32'h0);
      check_eq($sformatf("v%0d.count", i), {29'd0, count}, 32'd1);
      check_head(i, 32'h100 + 32'(4 * i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq($sformatf("v%0d.empty", i), {31'd0, out_valid}, 32'd0);
    end

    // Program order: mul then sra
    drive_in(1'b1, vecs[1].instr, 32'h180);
    tick();
    drive_in(1'b1, vecs[2].instr, 32'h184);
    tick();
    drive_in(1'b0, 32'h0, 32'h0);
    check_eq("ord.count", {29'd0, count}, 32'd2);
    check_head(1, 32'h180);
    out_ready = 1'b1;
    tick();
    check_head(2, 32'h184);
    tick();
    out_ready = 1'b0;
    check_eq("ord.empty", {29'd0, count}, 32'd0);

    // Simultaneous push and pop keeps the count
    drive_in(1'b1, vecs[0].instr, 32'h190);
    tick();
    drive_in(1'b1, vecs[0].instr, 32'h194);
    out_ready = 1'b1;
    tick();
    drive_in(1'b0, 32'h0, 32'h0);
    check_eq("pp.count", {29'd0, count}, 32'd1);
    check_eq("pp.pc",    out_pc,         32'h194);
    tick();
    out_ready = 1'b0;
    check_eq("pp.empty", {29'd0, count}, 32'd0);

    // Back-pressure: four fill the queue, the fifth waits
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 32'h00000013 | (32'(i + 1) << 7), 32'h200 + 32'(4 * i));
      exp_q.push_back(32'h200 + 32'(4 * i));
      tick();
    end
    check_eq("full.count",    {29'd0, count},    32'd4);
    check_eq("full.in_ready", {31'd0, in_ready}, 32'd0);
    drive_in(1'b1, 32'h00500293, 32'h210);
    tick();
    check_eq("full.hold", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    pops = 0;
    cyc  = 0;
    while (pops < 5 && cyc < 20) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          exp_pc = exp_q.pop_front();
          check_eq($sformatf("full.pop%0d", pops), out_pc, exp_pc);
        end else begin
          check_eq("full.extra_pop", out_pc, 32'hFFFFFFFF);
        end
        pops++;
      end
      accepted = in_valid && in_ready;
      if (accepted) exp_q.push_back(in_pc);
      tick();
      if (accepted) drive_in(1'b0, 32'h0, 32'h0);
      cyc++;
    end
    out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0);
    check_eq("full.pops",  pops,             32'd5);
    check_eq("full.count", {29'd0, count},   32'd0);
    check_eq("full.left",  exp_q.size(),     32'd0);

    // Flush with an instruction offered in the same cycle
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, vecs[0].instr, 32'h300 + 32'(4 * i));
      tick();
    end
    check_eq("fl.pre", {29'd0, count}, 32'd3);
    flush = 1'b1;
    drive_in(1'b1, vecs[1].instr, 32'h30C);
    tick();
    flush = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0);
    check_eq("fl.count",     {29'd0, count},     32'd0);
    check_eq("fl.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl.in_ready",  {31'd0, in_ready},  32'd1);
    tick();
    check_eq("fl.absent", {29'd0, count}, 32'd0);
    drive_in(1'b1, vecs[2].instr, 32'h310);
    tick();
    drive_in(1'b0, 32'h0, 32'h0);
    check_eq("fl.after_cnt", {29'd0, count}, 32'd1);
    check_head(2, 32'h310);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a cycle
    drive_in(1'b1, vecs[0].instr, 32'h400);
    tick();
    drive_in(1'b1, vecs[1].instr, 32'h404);
    tick();
    drive_in(1'b0, 32'h0, 32'h0);
    check_eq("ar.pre", {29'd0, count}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar.count",     {29'd0, count},     32'd0);
    check_eq("ar.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ar.in_ready",  {31'd0, in_ready},  32'd1);
    #2;
    rst = 1'b0;
    tick();
    drive_in(1'b1, vecs[3].instr, 32'h408);
    tick();
    drive_in(1'b0, 32'h0, 32'h0);
    check_head(3, 32'h408);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
